pp_buffer: RTL and testbench

Parametrised two-bank ping-pong buffer; the successor of the fixed 8-bit ping-pong block. The writer fills one bank while the reader drains the other. Width and depth are generic, frames may be shorter than a bank (`in_last`), and both sides have flow control. It sits between a bursty producer and a consumer that stalls with `busy`.

---
 rtl/pp_pkg.sv | 16 +
 rtl/pp_bank.sv | 68 ++++++
 rtl/pp_buffer.sv | 107 ++++++++++
 tb/tb_pp_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared types and helpers for the two-bank ping-pong buffer.
// Provides the bank state enum and the length/count width helper.
package pp_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } bank_state_t;

   // Width able to hold a length of 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pp_bank.sv
// One storage bank: DATA_W x DEPTH words, frame length and bank state.
// Ports: write port (wr_en/wr_addr/wr_data), close strobe with close_len,
// read address/data, free strobe, and state/len outputs.
module pp_bank
   import pp_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = cnt_w(DEPTH),
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              close,
   input  logic [CNT_W-1:0]  close_len,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              free,
   output bank_state_t       state,
   output logic [CNT_W-1:0]  len
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   bank_state_t       state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;

   // free only occurs while FULL and writes only while not FULL,
   // so the two strobes never collide on the same bank.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      if (free) begin
         state_d = EMPTY;
      end
      if (wr_en) begin
         if (close) begin
            state_d = FULL;
            len_d   = close_len;
         end else begin
            state_d = FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];
   assign state   = state_q;
   assign len     = len_q;

endmodule

// File: rtl/pp_buffer.sv
// Two-bank ping-pong buffer: writer fills one bank, reader drains the other.
// Ports: clk, rst, in_valid/in_data/in_last/in_ready (write side),
// busy/out_valid/out_data/out_last (read side), bank_full per bank.
module pp_buffer
   import pp_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        bank_full
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

   logic          wb_q, wb_d;
   logic          rb_q, rb_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   bank_state_t       st_w   [2];
   logic [CNT_W-1:0]  len_w  [2];
   logic [DATA_W-1:0] rdat_w [2];

   logic             wr_acc;
   logic             wr_close;
   logic [CNT_W-1:0] close_len;
   logic             rd_xfer;
   logic             rd_free;

   always_comb begin
      in_ready  = (st_w[wb_q] != FULL);
      out_valid = (st_w[rb_q] == FULL);
      wr_acc    = in_valid & in_ready;
      // A bank closes on an explicit frame end or on its last slot.
      wr_close  = wr_acc & (in_last | (wr_ptr_q == PTR_MAX));
      close_len = CNT_W'(wr_ptr_q) + CNT_W'(1);
      out_last  = out_valid &
                  (CNT_W'(rd_ptr_q) == (len_w[rb_q] - CNT_W'(1)));
      rd_xfer   = out_valid & ~busy;
      rd_free   = rd_xfer & out_last;
      // Forced to zero when idle so reset presents a clean bus.
      out_data  = out_valid ? rdat_w[rb_q] : '0;
      bank_full = {st_w[1] == FULL, st_w[0] == FULL};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wb_d     = wb_q ^ wr_close;
      rb_d     = rb_q ^ rd_free;
      if (wr_acc) begin
         wr_ptr_d = wr_close ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_xfer) begin
         rd_ptr_d = rd_free ? '0 : rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q     <= 1'b0;
         rb_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wb_q     <= wb_d;
         rb_q     <= rb_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pp_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .CNT_W  (CNT_W),
         .AW     (AW)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_acc & (wb_q == 1'(b))),
         .wr_addr   (wr_ptr_q),
         .wr_data   (in_data),
         .close     (wr_close),
         .close_len (close_len),
         .rd_addr   (rd_ptr_q),
         .rd_data   (rdat_w[b]),
         .free      (rd_free & (rb_q == 1'(b))),
         .state     (st_w[b]),
         .len       (len_w[b])
      );
   end

endmodule

// File: tb/tb_pp_buffer.sv
// Self-checking bench for pp_buffer (DATA_W=8, DEPTH=4).
// Directed scenarios then random traffic against a frame-queue model.
module tb_pp_buffer;

   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       busy;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic [1:0] bank_full;

   always #5 clk = ~clk;

   pp_buffer #(
      .DATA_W (8),
      .DEPTH  (DEP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .bank_full (bank_full)
   );

   int compared   = 0;
   int mismatched = 0;

   // Model: closed frames waiting to be read (flattened words plus
   // per-frame length and bank), and the frame currently being written.
   logic [7:0] cl_data [$];
   int         cl_len  [$];
   int         cl_bank [$];
   logic [7:0] part    [$];
   int         rd_idx;
   int         nxt_bank;
   int         tog;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cl_data.delete();
      cl_len.delete();
      cl_bank.delete();
      part.delete();
      rd_idx   = 0;
      nxt_bank = 0;
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit l,
                       input bit b, output bit acc);
      logic       e_rdy;
      logic       e_val;
      logic       e_last;
      logic [1:0] e_bf;
      bit         xfer;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      busy     = b;
      e_rdy  = (cl_len.size() < 2);
      e_val  = (cl_len.size() > 0);
      e_last = e_val && (rd_idx == cl_len[0] - 1);
      e_bf   = 2'b00;
      foreach (cl_bank[i]) e_bf[cl_bank[i]] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_val));
      chk("out_last", 32'(out_last), 32'(e_last));
      chk("bank_full", 32'(bank_full), 32'(e_bf));
      if (e_val) chk("out_data", 32'(out_data), 32'(cl_data[rd_idx]));
      acc  = v && e_rdy;
      xfer = e_val && !b;
      @(posedge clk);
      if (xfer) begin
         if (e_last) begin
            repeat (cl_len[0]) void'(cl_data.pop_front());
            void'(cl_len.pop_front());
            void'(cl_bank.pop_front());
            rd_idx = 0;
         end else begin
            rd_idx++;
         end
      end
      if (acc) begin
         part.push_back(d);
         if (l || part.size() == DEP) begin
            foreach (part[i]) cl_data.push_back(part[i]);
            cl_len.push_back(part.size());
            cl_bank.push_back(nxt_bank);
            nxt_bank ^= 1;
            part.delete();
         end
      end
   endtask

   function automatic bit pick_busy(input int mode);
      case (mode)
         1:       return 1'b1;
         2:       return tog[0];
         3:       return ($urandom % 3) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input logic [7:0] d, input bit l, input int mode);
      bit acc = 1'b0;
      for (int n = 0; n < 40 && !acc; n++) begin
         tog++;
         step(1'b1, d, l, pick_busy(mode), acc);
      end
      chk("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic drain(input int mode);
      bit acc;
      for (int n = 0; n < 80 && cl_len.size() > 0; n++) begin
         tog++;
         step(1'b0, 8'h00, 1'b0, pick_busy(mode), acc);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, acc);
      chk("drain_done", 32'(out_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      busy     = 1'b0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_bank_full", 32'(bank_full), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      busy     = 1'b0;
      tog      = 0;
      model_reset();
      do_reset();

      for (int i = 1; i <= 8; i++) push(8'(i), 1'b0, 0);
      drain(0);

      push(8'hA0, 1'b0, 0);
      push(8'hA1, 1'b1, 0);
      drain(0);

      for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b0, 1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h28, 1'b0, 1'b1, acc);
      chk("bp_stalled", 32'(in_ready), 32'd0);
      for (int i = 8; i < 12; i++) push(8'h20 + 8'(i), 1'b0, 0);
      drain(0);

      for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0, 2);
      drain(2);

      for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b0, 1);
      do_reset();
      push(8'h55, 1'b1, 0);
      drain(0);

      push(8'h11, 1'b1, 0);
      push(8'h22, 1'b1, 0);
      push(8'h33, 1'b1, 0);
      drain(0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, 8'($urandom),
              ($urandom % 4) == 0, ($urandom % 3) == 0, acc);
      end
      drain(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
